// File: rtl/xprop_result_monitor.sv
// xprop_result_monitor
// Synthesizable scoreboard for dual-rail (value + unknown mask) results.
// Each accepted sample is compared against a dual-rail expected word. The
// block counts run cycles, accepted samples, samples with a known-bit
// mismatch and unexpected unknown bits, and ends the run at a programmable
// cycle limit.
//
// Optional feature: define XPROP_FIRST_FAIL_CAPTURE_EN to add the
// fail_valid/fail_cycle/fail_val/fail_xmask outputs. These hold the first
// failing sample of the current run.
//
// Handshake: a sample transfers on a rising clk edge when in_valid && in_ready.
// in_ready is high only in RUN and does not depend on in_valid. Samples
// offered outside RUN are dropped without side effects.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DONE.
module xprop_result_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      cycle_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     res_val,
  input  logic [W-1:0]     res_xmask,
  input  logic [W-1:0]     exp_val,
  input  logic [W-1:0]     exp_xmask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      cycle_count,
  output logic [31:0]      sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] xbit_count,
`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
  output logic             fail_valid,
  output logic [31:0]      fail_cycle,
  output logic [W-1:0]     fail_val,
  output logic [W-1:0]     fail_xmask,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Popcount width for up to W unknown bits per sample. The sum is one bit
  // wider than the larger operand, so an overflow past the counter maximum
  // is always visible before clamping.
  localparam int PC_W  = $clog2(W + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic               run_start;
  logic [31:0]        max_q;
  logic [31:0]        cycle_count_q;
  logic [31:0]        sample_count_q;
  logic [CNT_W-1:0]   mismatch_count_q;
  logic [CNT_W-1:0]   xbit_count_q;

  logic               accept;
  logic [W-1:0]       care;
  logic [W-1:0]       mism;
  logic [W-1:0]       xb;
  logic               mism_any;
  logic               xb_any;
  logic [PC_W-1:0]    xb_pop;
  logic [SUM_W-1:0]   mism_sum;
  logic [SUM_W-1:0]   xb_sum;
  logic [CNT_W-1:0]   mism_next;
  logic [CNT_W-1:0]   xb_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. run_start marks the edge that latches cycle_max and
  // clears the run counters. It fires from IDLE or DONE only, so a start
  // pulse during RUN has no effect.
  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          run_start = 1'b1;
        end
      end
      S_RUN: begin
        if (cycle_count_q == max_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          run_start = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-sample comparison. Bits marked don't-care in exp_xmask never count.
  // A bit that is X in the result counts as an unknown bit, not as a
  // mismatch.
  always_comb begin
    accept   = in_valid && (state_q == S_RUN);
    care     = ~exp_xmask;
    mism     = care & ~res_xmask & (res_val ^ exp_val);
    xb       = care & res_xmask;
    mism_any = |mism;
    xb_any   = |xb;
  end

  // Count the unexpected unknown bits of the current sample.
  always_comb begin
    xb_pop = '0;
    for (int i = 0; i < W; i++) begin
      xb_pop = xb_pop + PC_W'(xb[i]);
    end
  end

  // Saturating counter increments. Clamping at all-ones also covers an add
  // that would step past the limit, not only one that starts there.
  always_comb begin
    mism_sum  = SUM_W'(mismatch_count_q) + SUM_W'(mism_any);
    xb_sum    = SUM_W'(xbit_count_q) + SUM_W'(xb_pop);
    mism_next = (mism_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : mism_sum[CNT_W-1:0];
    xb_next   = (xb_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : xb_sum[CNT_W-1:0];
  end

  // Run bookkeeping: latch the limit at start, advance the cycle index
  // during RUN, and register the counters for each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q            <= '0;
      cycle_count_q    <= '0;
      sample_count_q   <= '0;
      mismatch_count_q <= '0;
      xbit_count_q     <= '0;
    end else if (run_start) begin
      max_q            <= cycle_max;
      cycle_count_q    <= '0;
      sample_count_q   <= '0;
      mismatch_count_q <= '0;
      xbit_count_q     <= '0;
    end else if (state_q == S_RUN) begin
      if (cycle_count_q != max_q) begin
        cycle_count_q <= cycle_count_q + 32'd1;
      end
      if (accept) begin
        sample_count_q   <= sample_count_q + 32'd1;
        mismatch_count_q <= mism_next;
        xbit_count_q     <= xb_next;
      end
    end
  end

`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
  logic          fail_valid_q;
  logic [31:0]   fail_cycle_q;
  logic [W-1:0]  fail_val_q;
  logic [W-1:0]  fail_xmask_q;

  // Capture the first failing sample of a run. Later failures leave the
  // capture untouched until the next run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_cycle_q <= '0;
      fail_val_q   <= '0;
      fail_xmask_q <= '0;
    end else if (run_start) begin
      fail_valid_q <= 1'b0;
      fail_cycle_q <= '0;
      fail_val_q   <= '0;
      fail_xmask_q <= '0;
    end else if (accept && (mism_any || xb_any) && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_cycle_q <= cycle_count_q;
      fail_val_q   <= res_val;
      fail_xmask_q <= res_xmask;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_cycle = fail_cycle_q;
  assign fail_val   = fail_val_q;
  assign fail_xmask = fail_xmask_q;
`endif

  assign in_ready       = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (mismatch_count_q == '0) && (xbit_count_q == '0);
  assign cycle_count    = cycle_count_q;
  assign sample_count   = sample_count_q;
  assign mismatch_count = mismatch_count_q;
  assign xbit_count     = xbit_count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_xprop_result_monitor.sv
// Bench for xprop_result_monitor: directed and randomized runs. Each run's
// expected final status is pushed into exp_q. A monitor pops and compares
// one entry whenever done rises.
module tb_xprop_result_monitor;

  localparam int W     = 16;
  localparam int CNT_W = 4;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  localparam int K_BASIC = 0;
  localparam int K_XPROP = 1;
  localparam int K_DC    = 2;
  localparam int K_MISM  = 3;
  localparam int K_XALL  = 4;
  localparam int K_FIRST = 5;
  localparam int K_RAND  = 6;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      cycle_max;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     res_val;
  logic [W-1:0]     res_xmask;
  logic [W-1:0]     exp_val;
  logic [W-1:0]     exp_xmask;
  logic             busy;
  logic             done;
  logic             pass;
  logic [31:0]      cycle_count;
  logic [31:0]      sample_count;
  logic [CNT_W-1:0] mismatch_count;
  logic [CNT_W-1:0] xbit_count;
  logic [1:0]       state_dbg;
`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [31:0]      fail_cycle;
  logic [W-1:0]     fail_val;
  logic [W-1:0]     fail_xmask;
`endif

  xprop_result_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cycle_max      (cycle_max),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .res_val        (res_val),
    .res_xmask      (res_xmask),
    .exp_val        (exp_val),
    .exp_xmask      (exp_xmask),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .cycle_count    (cycle_count),
    .sample_count   (sample_count),
    .mismatch_count (mismatch_count),
    .xbit_count     (xbit_count),
`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
    .fail_valid     (fail_valid),
    .fail_cycle     (fail_cycle),
    .fail_val       (fail_val),
    .fail_xmask     (fail_xmask),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int unsigned cyc;
    int unsigned smp;
    int unsigned mism;
    int unsigned xb;
    bit          pass;
    bit          fv;
    int unsigned fcyc;
    logic [W-1:0] fval;
    logic [W-1:0] fxm;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  // Reference model accumulators for the run in progress.
  int unsigned  m_smp, m_mism, m_xb, m_fcyc;
  bit           m_fv;
  logic [W-1:0] m_fval, m_fxm;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  // Apply the comparison rules directly to one accepted sample.
  task automatic model_sample(input int unsigned c, input logic [W-1:0] rv, input logic [W-1:0] rx,
                              input logic [W-1:0] ev, input logic [W-1:0] ex);
    logic [W-1:0] care, mism, xbits;
    care  = ~ex;
    mism  = care & ~rx & (rv ^ ev);
    xbits = care & rx;
    m_smp++;
    if (mism != '0) m_mism = sat_add(m_mism, 1);
    m_xb = sat_add(m_xb, $countones(xbits));
    if (!m_fv && (mism != '0 || xbits != '0)) begin
      m_fv   = 1'b1;
      m_fcyc = c;
      m_fval = rv;
      m_fxm  = rx;
    end
  endtask

  // Stimulus pattern for RUN cycle c of a given kind.
  task automatic gen(input int kind, input int unsigned c, output logic v, output logic [W-1:0] rv,
                     output logic [W-1:0] rx, output logic [W-1:0] ev, output logic [W-1:0] ex);
    v = 1'b1; rv = 16'h4200; rx = '0; ev = 16'h4200; ex = '0;
    case (kind)
      K_XPROP: rx = 16'h0400;
      K_DC: begin rv = 16'h8001; ev = 16'h0001; ex = 16'h8000; rx = 16'h8000; end
      K_MISM: begin rv = 16'h1234; ev = 16'h4321; end
      K_XALL: rx = 16'hFFFF;
      K_FIRST: begin
        if (c == 3) rx = 16'h0010;
        if (c == 6) begin rx = 16'h0020; rv = 16'h4201; end
      end
      K_RAND: begin
        v  = ($urandom_range(0, 3) != 0);
        ev = 16'($urandom);
        ex = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : '0;
        rx = ($urandom_range(0, 4) == 0) ? (16'h1 << $urandom_range(0, 15)) : '0;
        rv = ev ^ (($urandom_range(0, 5) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
        rv = rv ^ (rx & 16'($urandom));
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Starts a run, drives max+1 RUN cycles, pushes the
  // expected final status, then holds in DONE feeding samples that must be
  // dropped.
  task automatic run(input int unsigned max, input int kind);
    logic v;
    logic [W-1:0] rv, rx, ev, ex;
    exp_t e;
    start = 1'b1; cycle_max = max;
    in_valid = 1'b1; res_val = 16'hDEAD; res_xmask = 16'h00FF; exp_val = '0; exp_xmask = '0;
    @(posedge clk); #1;
    start = 1'b0;
    m_smp = 0; m_mism = 0; m_xb = 0; m_fv = 1'b0; m_fcyc = 0; m_fval = '0; m_fxm = '0;
    for (int unsigned c = 0; c <= max; c++) begin
      gen(kind, c, v, rv, rx, ev, ex);
      in_valid = v; res_val = rv; res_xmask = rx; exp_val = ev; exp_xmask = ex;
      if (kind == K_RAND) start = ($urandom_range(0, 5) == 0);
      if (v) model_sample(c, rv, rx, ev, ex);
      @(negedge clk);
      check("in_ready_run", in_ready, 1'b1);
      check("busy_run", busy, 1'b1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    e.cyc = max; e.smp = m_smp; e.mism = m_mism; e.xb = m_xb;
    e.pass = (m_mism == 0) && (m_xb == 0);
    e.fv = m_fv; e.fcyc = m_fcyc; e.fval = m_fval; e.fxm = m_fxm;
    exp_q.push_back(e);
    last_exp = e;
    in_valid = 1'b1; res_val = 16'h0F0F; res_xmask = 16'h3000; exp_val = 16'hF0F0; exp_xmask = '0;
    repeat (2) begin
      @(negedge clk);
      check("done_hold", done, 1'b1);
      check("in_ready_done", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("done_sample_hold", sample_count, last_exp.smp);
    check("done_mism_hold", mismatch_count, last_exp.mism);
    check("done_xbit_hold", xbit_count, last_exp.xb);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("cycle_count", cycle_count, e.cyc);
          check("sample_count", sample_count, e.smp);
          check("mismatch_count", mismatch_count, e.mism);
          check("xbit_count", xbit_count, e.xb);
          check("pass", pass, e.pass);
`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
          check("fail_valid", fail_valid, e.fv);
          check("fail_cycle", fail_cycle, e.fcyc);
          check("fail_val", fail_val, e.fval);
          check("fail_xmask", fail_xmask, e.fxm);
`endif
        end
      end
      done_prev = done;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_cycle"}, cycle_count, 32'd0);
    check({tag, "_sample"}, sample_count, 32'd0);
    check({tag, "_mism"}, mismatch_count, '0);
    check({tag, "_xbit"}, xbit_count, '0);
`ifdef XPROP_FIRST_FAIL_CAPTURE_EN
    check({tag, "_fail_valid"}, fail_valid, 1'b0);
    check({tag, "_fail_cycle"}, fail_cycle, 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; cycle_max = '0; in_valid = 1'b0;
    res_val = '0; res_xmask = '0; exp_val = '0; exp_xmask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Samples offered in IDLE are dropped.
    in_valid = 1'b1; res_val = 16'h1111; res_xmask = 16'hFFFF; exp_val = 16'h2222;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_sample", sample_count, 32'd0);
    check("idle_mism", mismatch_count, '0);
    check("idle_xbit", xbit_count, '0);
    check("idle_busy", busy, 1'b0);

    run(10, K_BASIC);
    run(2,  K_XPROP);
    run(3,  K_DC);
    run(19, K_MISM);
    run(0,  K_XALL);
    run(0,  K_BASIC);
    run(9,  K_FIRST);
    run(4,  K_BASIC);
    for (int i = 0; i < 10; i++) run($urandom_range(0, 30), K_RAND);

    // Reset in the middle of a run: everything returns to zero at once.
    start = 1'b1; cycle_max = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; res_val = 16'h1234; exp_val = 16'h4321; res_xmask = 16'h0003; exp_xmask = '0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(3, K_XPROP);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
